fp_mul_core: RTL and testbench
==============================

// Module: fp_mul_core
// PURPOSE
//   Sequential IEEE-754 single-precision multiply core: unpacks two operands, forms the 48-bit
//   mantissa product with a radix-2 shift-add engine, normalizes it and computes the biased exponent.
//   Sits directly upstream of the rounding stage and drives all of its data and control inputs.
//   Output contract: hidden bit at mantissa_out[46], guard bit at [22].
// PARAMETERS
//   MANT_W  24   mantissa width incl. hidden bit; product width = 2*MANT_W
//   EXP_W   8    exponent field width
//   BIAS    127  exponent bias
// PORTS
//   clk              in   1   clock, rising edge
//   reset            in   1   asynchronous, active-high reset
//   start            in   1   1-cycle request; sampled only in IDLE or DONE
//   a_in             in   32  operand A {sign, exp[7:0], frac[22:0]}
//   b_in             in   32  operand B
//   busy             out  1   high in MULT and NORM
//   mantissa_out     out  48  normalized product; [47]=0, [46]=hidden bit
//   exponent_out     out  9   biased result exponent, 1..254 when valid
//   sign_out         out  1   a_in[31] ^ b_in[31]
//   mux_en_rounding  out  1   exception: exponent overflow/underflow or Inf/NaN operand
//   enable_rounding  out  1   result valid; level held through DONE
//   no_start         out  1   high in IDLE (no result held)
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0, except no_start=1. Reset mid-operation aborts immediately.
//   FSM:
//     IDLE -start-> MULT: latch operands; cnt=0.
//     MULT: 24 cycles; cnt 0..23; -> NORM when cnt==23.
//     NORM: 1 cycle -> DONE.
//     DONE -start-> MULT (new op); otherwise holds.
//   start in MULT/NORM: ignored, no queuing.
//   Unpack: mA={exp!=0, frac}. exp==0 is treated as zero (denormals flushed).
//   Multiply: shift-add, one multiplier bit per cycle, LSB first. 48-bit accumulator, no overflow possible.
//   Exponent: e = ea + eb - BIAS in 10-bit signed arithmetic.
//   NORM:
//     - If p[47]=1: mantissa_out = p>>1, with old p[0] ORed into new bit 0 (sticky kept); e = e + 1.
//     - Else: mantissa_out = p.
//   Exceptions, decided in NORM, priority order:
//     1. Either exponent field == 255 -> mux_en_rounding=1.
//     2. Else either operand zero -> mantissa_out=0, exponent_out=0, mux_en_rounding=0, sign kept.
//     3. Else e>254 or e<1 -> mux_en_rounding=1.
//     4. Else exponent_out = e[8:0], mux_en_rounding=0.
//   Output timing:
//     - All result outputs update on the NORM->DONE edge.
//     - enable_rounding=1 and no_start=0 from that edge.
//     - They stay stable until the next accepted start.
//   Latency: enable_rounding rises 26 clock edges after the edge that samples start.
//   On an accepted start from DONE: enable_rounding and mux_en_rounding drop to 0 on the same edge;
//   data outputs hold their old values until the next NORM.
//   Throughput: one operation per 26 cycles; back-to-back start in DONE is allowed.
// TESTING
//   1. a=3FC00000, b=40000000 (1.5*2.0): after 26 edges mantissa_out=6000_0000_0000,
//      exponent_out=080, sign_out=0, enable_rounding=1; downstream result 40400000.
//   2. a=b=3FC00000 (1.5*1.5): normalization shift taken; mantissa_out=4800_0000_0000,
//      exponent_out=080; downstream result 40100000.
//   3. a=b=7F000000: e=381 -> mux_en_rounding=1, enable_rounding=1.
//      a=b=00800000: e=-125 -> mux_en_rounding=1.
//   4. a=00000000, b=C0000000: mantissa_out=0, exponent_out=0, sign_out=1, mux_en_rounding=0.
//      a=7F800000 (Inf) x 3F800000: mux_en_rounding=1.
//   5. start pulsed at cycle 5 of MULT with different operands: ignored; original result
//      delivered at the original time.
//      Back-to-back start in DONE: enable_rounding drops on the start edge.
//   6. reset asserted at cycle 12 of MULT: outputs 0 and no_start=1 asynchronously.
//      A new start after release completes normally with 26-cycle latency.

Source files
------------

// File: rtl/fp_mul_core.sv
// fp_mul_core
//   Sequential IEEE-754 single-precision multiply core. It unpacks two operands and
//   forms the 48-bit mantissa product with a radix-2 shift-add engine, one multiplier
//   bit per cycle, LSB first. It then normalizes the product, computes the biased
//   exponent and presents the result to the downstream rounding stage.
//   A result is produced 26 cycles after an accepted start.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset; aborts any operation in flight
//   start            1-cycle request, accepted only in IDLE or DONE
//   a_in, b_in       operands {sign, exp[7:0], frac[22:0]}
//   busy             high while multiplying or normalizing
//   mantissa_out     normalized product: [47]=0, hidden bit at [46], guard bit at [22]
//   exponent_out     biased result exponent (1..254 when no exception)
//   sign_out         a_in[31] ^ b_in[31]
//   mux_en_rounding  exception: exponent out of range or Inf/NaN operand
//   enable_rounding  result valid; held high through DONE
//   no_start         high while IDLE (no result held)
module fp_mul_core #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           a_in,
  input  logic [31:0]           b_in,
  output logic                  busy,
  output logic [2*MANT_W-1:0]   mantissa_out,
  output logic [EXP_W:0]        exponent_out,
  output logic                  sign_out,
  output logic                  mux_en_rounding,
  output logic                  enable_rounding,
  output logic                  no_start
);

  localparam int PW      = 2 * MANT_W;        // product width
  localparam int FRAC_W  = MANT_W - 1;        // stored fraction width
  localparam int EW      = EXP_W + 2;         // signed exponent working width
  localparam int CNT_W   = $clog2(MANT_W);
  localparam int EXP_MAX = (1 << EXP_W) - 2;  // largest finite biased exponent

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]          mcand_q, mcand_d;   // multiplicand, shifted left each cycle
  logic [MANT_W-1:0]      mplier_q, mplier_d; // multiplier, shifted right each cycle
  logic [PW-1:0]          acc_q, acc_d;
  logic [EXP_W-1:0]       ea_q, ea_d;
  logic [EXP_W-1:0]       eb_q, eb_d;
  logic                   sign_q, sign_d;

  logic [PW-1:0]          mant_out_q, mant_out_d;
  logic [EXP_W:0]         exp_out_q, exp_out_d;
  logic                   sign_out_q, sign_out_d;
  logic                   mux_en_q, mux_en_d;
  logic                   enable_q, enable_d;

  logic signed [EW-1:0]   e_raw, e_adj;
  logic [PW-1:0]          p_norm;

  // Product of two [1,2) mantissas lies in [1,4); a single right shift brings it back
  // to [1,2). The bit shifted out is folded into bit 0 so rounding still sees it.
  function automatic logic [PW-1:0] normalize(input logic [PW-1:0] p);
    if (p[PW-1])
      normalize = {1'b0, p[PW-1:2], p[1] | p[0]};
    else
      normalize = p;
  endfunction

  function automatic logic exp_out_of_range(input logic signed [EW-1:0] e);
    exp_out_of_range = (e > $signed(EW'(EXP_MAX))) || (e < $signed(EW'(1)));
  endfunction

  always_comb begin
    e_raw  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(EW'(BIAS));
    e_adj  = acc_q[PW-1] ? e_raw + $signed(EW'(1)) : e_raw;
    p_norm = normalize(acc_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    sign_d     = sign_q;
    mant_out_d = mant_out_q;
    exp_out_d  = exp_out_q;
    sign_out_d = sign_out_q;
    mux_en_d   = mux_en_q;
    enable_d   = enable_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Accepting a new op retracts the previous result's valid/exception flags
          // immediately; data outputs keep their old values until the next NORM.
          state_d  = MULT;
          cnt_d    = '0;
          acc_d    = '0;
          ea_d     = a_in[FRAC_W+EXP_W-1:FRAC_W];
          eb_d     = b_in[FRAC_W+EXP_W-1:FRAC_W];
          sign_d   = a_in[31] ^ b_in[31];
          // A zero exponent field means zero: denormals are flushed by clearing
          // the hidden bit.
          mcand_d  = {{MANT_W{1'b0}}, (a_in[FRAC_W+EXP_W-1:FRAC_W] != '0), a_in[FRAC_W-1:0]};
          mplier_d = {(b_in[FRAC_W+EXP_W-1:FRAC_W] != '0), b_in[FRAC_W-1:0]};
          enable_d = 1'b0;
          mux_en_d = 1'b0;
        end
      end

      MULT: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MANT_W - 1))
          state_d = NORM;
      end

      NORM: begin
        state_d    = DONE;
        enable_d   = 1'b1;
        sign_out_d = sign_q;
        mant_out_d = p_norm;
        exp_out_d  = e_adj[EXP_W:0];
        // Inf/NaN takes priority over zero so Inf*0 is still flagged.
        if ((ea_q == '1) || (eb_q == '1)) begin
          mux_en_d = 1'b1;
        end else if ((ea_q == '0) || (eb_q == '0)) begin
          mant_out_d = '0;
          exp_out_d  = '0;
          mux_en_d   = 1'b0;
        end else begin
          mux_en_d = exp_out_of_range(e_adj);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      sign_q     <= 1'b0;
      mant_out_q <= '0;
      exp_out_q  <= '0;
      sign_out_q <= 1'b0;
      mux_en_q   <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      sign_q     <= sign_d;
      mant_out_q <= mant_out_d;
      exp_out_q  <= exp_out_d;
      sign_out_q <= sign_out_d;
      mux_en_q   <= mux_en_d;
      enable_q   <= enable_d;
    end
  end

  assign busy            = (state_q == MULT) || (state_q == NORM);
  assign no_start        = (state_q == IDLE);
  assign mantissa_out    = mant_out_q;
  assign exponent_out    = exp_out_q;
  assign sign_out        = sign_out_q;
  assign mux_en_rounding = mux_en_q;
  assign enable_rounding = enable_q;

endmodule

// File: tb/tb_fp_mul_core.sv
// Directed-vector bench for fp_mul_core. Each scenario task drives its own stimulus
// and checks results against hand-computed values.
module tb_fp_mul_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy;
  logic [47:0] mantissa_out;
  logic [8:0]  exponent_out;
  logic        sign_out, mux_en_rounding, enable_rounding, no_start;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_core dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .mantissa_out(mantissa_out), .exponent_out(exponent_out),
    .sign_out(sign_out), .mux_en_rounding(mux_en_rounding),
    .enable_rounding(enable_rounding), .no_start(no_start)
  );

  always #5 clk = ~clk;

  // Pulse start for exactly one rising edge; returns 1 time unit after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sampling edge counts as edge 1; the result appears on edge 26.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_edges(25);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    #3;
    n_checks++; if (no_start !== 1'b1) begin n_fail++; $display("FAIL rst_no_start got %0b want 1", no_start); end
    n_checks++; if (enable_rounding !== 1'b0) begin n_fail++; $display("FAIL rst_enable got %0b want 0", enable_rounding); end
    n_checks++; if (mux_en_rounding !== 1'b0) begin n_fail++; $display("FAIL rst_mux got %0b want 0", mux_en_rounding); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_checks++; if (mantissa_out !== 48'h0 || exponent_out !== 9'h0 || sign_out !== 1'b0) begin n_fail++; $display("FAIL rst_data got %h/%h/%0b want 0/0/0", mantissa_out, exponent_out, sign_out); end
    @(negedge clk); reset = 1'b0;
    wait_edges(2);
    n_checks++; if (no_start !== 1'b1 || enable_rounding !== 1'b0) begin n_fail++; $display("FAIL idle_hold got ns=%0b en=%0b want 1/0", no_start, enable_rounding); end
  endtask

  task automatic test_basic_latency;
    // 1.5 * 2.0
    start_op(32'h3FC00000, 32'h40000000);
    n_checks++; if (busy !== 1'b1 || no_start !== 1'b0) begin n_fail++; $display("FAIL lat_busy got busy=%0b ns=%0b want 1/0", busy, no_start); end
    wait_edges(24);
    n_checks++; if (enable_rounding !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lat_early got en=%0b busy=%0b want 0/1", enable_rounding, busy); end
    wait_edges(1);
    n_checks++; if (enable_rounding !== 1'b1) begin n_fail++; $display("FAIL lat_en got %0b want 1", enable_rounding); end
    n_checks++; if (mantissa_out !== 48'h6000_0000_0000) begin n_fail++; $display("FAIL basic_mant got %h want 600000000000", mantissa_out); end
    n_checks++; if (exponent_out !== 9'h080) begin n_fail++; $display("FAIL basic_exp got %h want 080", exponent_out); end
    n_checks++; if (sign_out !== 1'b0 || mux_en_rounding !== 1'b0) begin n_fail++; $display("FAIL basic_flags got s=%0b mux=%0b want 0/0", sign_out, mux_en_rounding); end
    n_checks++; if (busy !== 1'b0 || no_start !== 1'b0) begin n_fail++; $display("FAIL done_state got busy=%0b ns=%0b want 0/0", busy, no_start); end
    wait_edges(3);
    n_checks++; if (enable_rounding !== 1'b1 || mantissa_out !== 48'h6000_0000_0000) begin n_fail++; $display("FAIL done_hold got en=%0b m=%h want 1/600000000000", enable_rounding, mantissa_out); end
  endtask

  task automatic test_normalize;
    // 1.5 * 1.5 = 2.25: shift taken
    run_op(32'h3FC00000, 32'h3FC00000);
    n_checks++; if (mantissa_out !== 48'h4800_0000_0000 || exponent_out !== 9'h080) begin n_fail++; $display("FAIL norm_shift got %h/%h want 480000000000/080", mantissa_out, exponent_out); end
    // (2-2^-23)^2: shift taken, shifted-out 1 kept in bit 0
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF);
    n_checks++; if (mantissa_out !== 48'h7FFF_FF00_0001 || exponent_out !== 9'h080) begin n_fail++; $display("FAIL norm_sticky got %h/%h want 7FFFFF000001/080", mantissa_out, exponent_out); end
    // (1+2^-23)^2: no shift
    run_op(32'h3F800001, 32'h3F800001);
    n_checks++; if (mantissa_out !== 48'h4000_0100_0001 || exponent_out !== 9'h07F || mux_en_rounding !== 1'b0) begin n_fail++; $display("FAIL norm_noshift got %h/%h/%0b want 400001000001/07F/0", mantissa_out, exponent_out, mux_en_rounding); end
    // -1.5 * 2.0
    run_op(32'hBFC00000, 32'h40000000);
    n_checks++; if (sign_out !== 1'b1 || mantissa_out !== 48'h6000_0000_0000 || exponent_out !== 9'h080) begin n_fail++; $display("FAIL neg_sign got s=%0b %h/%h want 1/600000000000/080", sign_out, mantissa_out, exponent_out); end
  endtask

  task automatic test_back_to_back;
    // DONE holds -3.0; accept a new op straight away
    start_op(32'h3FC00000, 32'h3FC00000);
    n_checks++; if (enable_rounding !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_drop got en=%0b busy=%0b want 0/1", enable_rounding, busy); end
    n_checks++; if (mantissa_out !== 48'h6000_0000_0000 || sign_out !== 1'b1 || exponent_out !== 9'h080) begin n_fail++; $display("FAIL b2b_hold got %h/%0b/%h want 600000000000/1/080", mantissa_out, sign_out, exponent_out); end
    wait_edges(25);
    n_checks++; if (enable_rounding !== 1'b1 || mantissa_out !== 48'h4800_0000_0000 || sign_out !== 1'b0) begin n_fail++; $display("FAIL b2b_result got en=%0b %h s=%0b want 1/480000000000/0", enable_rounding, mantissa_out, sign_out); end
  endtask

  task automatic test_exceptions;
    // e = 254+254-127 = 381: overflow
    run_op(32'h7F000000, 32'h7F000000);
    n_checks++; if (mux_en_rounding !== 1'b1 || enable_rounding !== 1'b1) begin n_fail++; $display("FAIL ovf got mux=%0b en=%0b want 1/1", mux_en_rounding, enable_rounding); end
    // New start from DONE retracts the exception flag on the same edge
    start_op(32'h00800000, 32'h00800000);
    n_checks++; if (mux_en_rounding !== 1'b0 || enable_rounding !== 1'b0) begin n_fail++; $display("FAIL mux_drop got mux=%0b en=%0b want 0/0", mux_en_rounding, enable_rounding); end
    wait_edges(25);
    // e = 1+1-127 = -125: underflow
    n_checks++; if (mux_en_rounding !== 1'b1 || enable_rounding !== 1'b1) begin n_fail++; $display("FAIL unf got mux=%0b en=%0b want 1/1", mux_en_rounding, enable_rounding); end
    // 0 * -2.0
    run_op(32'h00000000, 32'hC0000000);
    n_checks++; if (mantissa_out !== 48'h0 || exponent_out !== 9'h0) begin n_fail++; $display("FAIL zero_data got %h/%h want 0/0", mantissa_out, exponent_out); end
    n_checks++; if (sign_out !== 1'b1 || mux_en_rounding !== 1'b0 || enable_rounding !== 1'b1) begin n_fail++; $display("FAIL zero_flags got s=%0b mux=%0b en=%0b want 1/0/1", sign_out, mux_en_rounding, enable_rounding); end
    // Inf * 1.0
    run_op(32'h7F800000, 32'h3F800000);
    n_checks++; if (mux_en_rounding !== 1'b1 || enable_rounding !== 1'b1) begin n_fail++; $display("FAIL inf got mux=%0b en=%0b want 1/1", mux_en_rounding, enable_rounding); end
    // Inf * 0: Inf/NaN outranks zero
    run_op(32'h7F800000, 32'h00000000);
    n_checks++; if (mux_en_rounding !== 1'b1) begin n_fail++; $display("FAIL inf_zero got mux=%0b want 1", mux_en_rounding); end
    // Back to a zero result so the next scenario starts from a distinct held value
    run_op(32'h00000000, 32'h3F800000);
  endtask

  task automatic test_start_ignored;
    start_op(32'h3FC00000, 32'h40000000);
    wait_edges(5);
    @(negedge clk);
    a_in = 32'h7F000000; b_in = 32'h7F000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = '0; b_in = '0;
    // that was edge 7; the original op finishes on edge 26
    wait_edges(18);
    n_checks++; if (enable_rounding !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ign_early got en=%0b busy=%0b want 0/1", enable_rounding, busy); end
    wait_edges(1);
    n_checks++; if (enable_rounding !== 1'b1 || mux_en_rounding !== 1'b0) begin n_fail++; $display("FAIL ign_flags got en=%0b mux=%0b want 1/0", enable_rounding, mux_en_rounding); end
    n_checks++; if (mantissa_out !== 48'h6000_0000_0000 || exponent_out !== 9'h080) begin n_fail++; $display("FAIL ign_data got %h/%h want 600000000000/080", mantissa_out, exponent_out); end
    wait_edges(3);
    n_checks++; if (busy !== 1'b0 || enable_rounding !== 1'b1) begin n_fail++; $display("FAIL ign_no_queue got busy=%0b en=%0b want 0/1", busy, enable_rounding); end
  endtask

  task automatic test_reset_midop;
    start_op(32'h3F800001, 32'h3F800001);
    wait_edges(11);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (no_start !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_state got ns=%0b busy=%0b want 1/0", no_start, busy); end
    n_checks++; if (enable_rounding !== 1'b0 || mux_en_rounding !== 1'b0) begin n_fail++; $display("FAIL arst_flags got en=%0b mux=%0b want 0/0", enable_rounding, mux_en_rounding); end
    n_checks++; if (mantissa_out !== 48'h0 || exponent_out !== 9'h0 || sign_out !== 1'b0) begin n_fail++; $display("FAIL arst_data got %h/%h/%0b want 0/0/0", mantissa_out, exponent_out, sign_out); end
    @(negedge clk); reset = 1'b0;
    wait_edges(2);
    n_checks++; if (no_start !== 1'b1 || enable_rounding !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got ns=%0b en=%0b want 1/0", no_start, enable_rounding); end
    start_op(32'h3F800001, 32'h3F800001);
    wait_edges(24);
    n_checks++; if (enable_rounding !== 1'b0) begin n_fail++; $display("FAIL post_rst_early got en=%0b want 0", enable_rounding); end
    wait_edges(1);
    n_checks++; if (enable_rounding !== 1'b1 || mantissa_out !== 48'h4000_0100_0001 || exponent_out !== 9'h07F) begin n_fail++; $display("FAIL post_rst_result got en=%0b %h/%h want 1/400001000001/07F", enable_rounding, mantissa_out, exponent_out); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_normalize();
    test_back_to_back();
    test_exceptions();
    test_start_ignored();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
